// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-ported word memory shared by an instruction-fetch port (IFU) and a
// load/store port (LSU). Each port holds at most one outstanding request in a
// one-entry pending slot. A small FSM (IDLE -> COUNT -> RESP) serves one
// request at a time, LSU before IFU, and answers after LATENCY cycles.
//
// Handshake: reqValid is a one-cycle pulse. It is accepted when that port's
// slot is empty, otherwise it is dropped and req_overflow sticks at 1. The slot
// stays occupied from acceptance until the cycle its respValid pulses, which
// lasts exactly one cycle; rdata is valid in that cycle and holds afterwards.
//
// Optional feature macro: MEM_RAND_DELAY_EN
//   When defined, a 16-bit Fibonacci LFSR adds 0..3 extra COUNT cycles to
//   every grant.
//
// Parameters
//   MEM_WORDS  number of 32-bit words (power of two)
//   LATENCY    base request-to-response cycles (>= 1)
//
// Ports
//   clock, reset                   clock; asynchronous active-high reset
//   ifu_reqValid, ifu_addr         fetch request pulse and byte address
//   ifu_respValid, ifu_rdata       fetch response pulse and data
//   lsu_reqValid, lsu_wen          load/store request pulse, 1 = store
//   lsu_addr, lsu_wdata, lsu_wmask byte address, store data, byte enables
//   lsu_respValid, lsu_rdata       load/store response pulse and data
//   req_overflow                   sticky: some request was dropped
//   fsm_state                      current FSM state (debug observation)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        req_overflow,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(MEM_WORDS);
    // Wide enough for LATENCY-1 plus up to 3 random extra cycles.
    localparam int CW = $clog2(LATENCY + 4) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            gnt_lsu;

    // Pending slots
    logic            ifu_slot_v;
    logic [AW-1:0]   ifu_slot_idx;
    logic            lsu_slot_v;
    logic            lsu_slot_wen;
    logic [AW-1:0]   lsu_slot_idx;
    logic [31:0]     lsu_slot_wdata;
    logic [3:0]      lsu_slot_wmask;

    // Backing storage, never reset
    logic [31:0]     mem [MEM_WORDS];

    // Effective request per port: the slot if occupied, else the live inputs.
    // This lets a LATENCY=1 grant complete at the same edge that fills the slot.
    logic            ifu_pend;
    logic            lsu_pend;
    logic [AW-1:0]   ifu_eff_idx;
    logic [AW-1:0]   lsu_eff_idx;
    logic            lsu_eff_wen;
    logic [31:0]     lsu_eff_wdata;
    logic [3:0]      lsu_eff_wmask;

    logic            start;
    logic            sel_lsu;
    logic            to_resp;
    logic            mem_we;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     rd_word;
    logic [1:0]      extra;
    logic [CW-1:0]   load_val;

    // Address bits outside the word index are ignored on purpose (wrap).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{ifu_addr[1:0], ifu_addr[31:AW+2],
                                lsu_addr[1:0], lsu_addr[31:AW+2]};

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign extra = lfsr[1:0];
`else
    assign extra = 2'b00;
`endif

    assign ifu_pend      = ifu_slot_v | ifu_reqValid;
    assign lsu_pend      = lsu_slot_v | lsu_reqValid;
    assign ifu_eff_idx   = ifu_slot_v ? ifu_slot_idx   : ifu_addr[2 +: AW];
    assign lsu_eff_idx   = lsu_slot_v ? lsu_slot_idx   : lsu_addr[2 +: AW];
    assign lsu_eff_wen   = lsu_slot_v ? lsu_slot_wen   : lsu_wen;
    assign lsu_eff_wdata = lsu_slot_v ? lsu_slot_wdata : lsu_wdata;
    assign lsu_eff_wmask = lsu_slot_v ? lsu_slot_wmask : lsu_wmask;

    assign load_val = CW'(LATENCY - 1) + {{(CW-2){1'b0}}, extra};
    assign start    = (state == IDLE) && (ifu_pend || lsu_pend);
    // In IDLE the arbiter picks now; otherwise the recorded grant applies.
    assign sel_lsu  = (state == IDLE) ? lsu_pend : gnt_lsu;
    // Edge that raises respValid: reads and store commit happen here.
    assign to_resp  = (start && (load_val == '0)) ||
                      ((state == COUNT) && (cnt <= CW'(1)));
    assign acc_idx  = sel_lsu ? lsu_eff_idx : ifu_eff_idx;
    assign rd_word  = mem[acc_idx];
    assign mem_we   = !reset && to_resp && sel_lsu && lsu_eff_wen;

    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lsu_eff_wmask[b]) begin
                    mem[lsu_eff_idx][8*b +: 8] <= lsu_eff_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            gnt_lsu        <= 1'b0;
            ifu_slot_v     <= 1'b0;
            ifu_slot_idx   <= '0;
            lsu_slot_v     <= 1'b0;
            lsu_slot_wen   <= 1'b0;
            lsu_slot_idx   <= '0;
            lsu_slot_wdata <= 32'h0;
            lsu_slot_wmask <= 4'h0;
            ifu_respValid  <= 1'b0;
            lsu_respValid  <= 1'b0;
            ifu_rdata      <= 32'h0;
            lsu_rdata      <= 32'h0;
            req_overflow   <= 1'b0;
        end else begin
            // IFU slot: freed by its response, else filled when empty.
            if (state == RESP && !gnt_lsu) begin
                ifu_slot_v <= 1'b0;
            end else if (ifu_reqValid && !ifu_slot_v) begin
                ifu_slot_v   <= 1'b1;
                ifu_slot_idx <= ifu_addr[2 +: AW];
            end

            if (state == RESP && gnt_lsu) begin
                lsu_slot_v <= 1'b0;
            end else if (lsu_reqValid && !lsu_slot_v) begin
                lsu_slot_v     <= 1'b1;
                lsu_slot_wen   <= lsu_wen;
                lsu_slot_idx   <= lsu_addr[2 +: AW];
                lsu_slot_wdata <= lsu_wdata;
                lsu_slot_wmask <= lsu_wmask;
            end

            if ((ifu_reqValid && ifu_slot_v) || (lsu_reqValid && lsu_slot_v)) begin
                req_overflow <= 1'b1;
            end

            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            if (to_resp) begin
                if (sel_lsu) begin
                    lsu_respValid <= 1'b1;
                    lsu_rdata     <= lsu_eff_wen ? 32'h0 : rd_word;
                end else begin
                    ifu_respValid <= 1'b1;
                    ifu_rdata     <= rd_word;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        gnt_lsu <= lsu_pend;
                        if (load_val == '0) begin
                            cnt   <= '0;
                            state <= RESP;
                        end else begin
                            cnt   <= load_val;
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
